// File: rtl/frida_seq_pkg.sv
// Shared types and constants for the FRIDA conversion controller.
// The state enum is exported so that benches and debug logic can decode dbg_state.
package frida_seq_pkg;

  localparam int N_BITS_DEF = 12;
  localparam int TW_DEF     = 8;
  localparam int CW_DEF     = 16;

  // Bit positions of the registered phase vector that drives the pad pairs
  localparam int PH_INIT  = 0;
  localparam int PH_SAMP  = 1;
  localparam int PH_CMP   = 2;
  localparam int PH_LOGIC = 3;
  localparam int N_PH     = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SAMP  = 3'd2,
    CMP   = 3'd3,
    WAIT  = 3'd4,
    LOGIC = 3'd5,
    DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/frida_seq_if.sv
// Result handshake between the conversion controller and the readout logic.
// A word transfers on every clk edge where res_valid & res_ready; res_data is
// stable while res_valid is high and not yet accepted, and valid never waits on ready.
interface frida_seq_if #(
  parameter int N_BITS = 12
);
  logic [N_BITS-1:0] res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (output res_data, output res_valid, input res_ready);
  modport slave  (input res_data, input res_valid, output res_ready);
endinterface

// File: rtl/frida_phase_timer.sv
// Down-counter for one sequencer phase: load a length (0 treated as 1),
// then 'last' is high during the final cycle of that phase.
module frida_phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          load,
  input  logic [TW-1:0] len,
  output logic          last
);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (len == '0) ? TW'(1) : len;
    end else if (cnt_q > TW'(1)) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign last = (cnt_q <= TW'(1));

endmodule

// File: rtl/frida_seq_ctrl.sv
// FRIDA conversion controller: sequences the four pad pairs, captures N_BITS
// comparator decisions MSB first and hands each result to a one-entry buffer.
module frida_seq_ctrl
  import frida_seq_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int TW     = TW_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_b,
  input  logic          run,
  input  logic          start,
  input  logic [TW-1:0] cfg_t_init,
  input  logic [TW-1:0] cfg_t_samp,
  input  logic [TW-1:0] cfg_t_cmp,
  input  logic [TW-1:0] cfg_t_wait,
  input  logic [TW-1:0] cfg_t_logic,
  input  logic          clr_flags,
  output logic          seq_init_p,
  output logic          seq_init_n,
  output logic          seq_samp_p,
  output logic          seq_samp_n,
  output logic          seq_cmp_p,
  output logic          seq_cmp_n,
  output logic          seq_logic_p,
  output logic          seq_logic_n,
  input  logic          comp_out_p,
  input  logic          comp_out_n,
  frida_seq_if.master   res,
  output logic          busy,
  output logic          overflow,
  output logic          bad_diff,
  output logic [CW-1:0] conv_count,
  output state_t        dbg_state
);

  localparam int KW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_t            state_q, state_d;
  logic [N_PH-1:0]   phase_q, phase_d;
  logic [TW-1:0]     sh_init, sh_samp, sh_cmp, sh_wait, sh_logic;
  logic              latch_cfg;
  logic              tmr_load, tmr_last;
  logic [TW-1:0]     tmr_len;
  logic [KW-1:0]     k_q;
  logic [N_BITS-1:0] shift_q, data_q;
  logic              valid_q, ovf_q, bad_q;
  logic [CW-1:0]     cnt_q;
  logic              p_meta, p_s, n_meta, n_s;
  logic              cap, push, pop;

  frida_phase_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .reset_b (reset_b),
    .load    (tmr_load),
    .len     (tmr_len),
    .last    (tmr_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Each transition reloads the timer with the length of the phase being entered.
  // Leaving IDLE/DONE uses the live cfg_t_init because the shadows latch on that same edge.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_len   = sh_init;
    latch_cfg = 1'b0;
    case (state_q)
      IDLE: if (run || start) begin
        state_d = INIT; tmr_load = 1'b1; tmr_len = cfg_t_init; latch_cfg = 1'b1;
      end
      INIT: if (tmr_last) begin
        state_d = SAMP; tmr_load = 1'b1; tmr_len = sh_samp;
      end
      SAMP: if (tmr_last) begin
        state_d = CMP; tmr_load = 1'b1; tmr_len = sh_cmp;
      end
      CMP: if (tmr_last) begin
        state_d = WAIT; tmr_load = 1'b1; tmr_len = sh_wait;
      end
      WAIT: if (tmr_last) begin
        state_d = LOGIC; tmr_load = 1'b1; tmr_len = sh_logic;
      end
      LOGIC: if (tmr_last) begin
        if (k_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = CMP; tmr_load = 1'b1; tmr_len = sh_cmp;
        end
      end
      DONE: if (run) begin
        state_d = INIT; tmr_load = 1'b1; tmr_len = cfg_t_init; latch_cfg = 1'b1;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase bits are decoded from the next state so the registered pads line up with state_q.
  always_comb begin
    phase_d = '0;
    case (state_d)
      INIT:    phase_d[PH_INIT]  = 1'b1;
      SAMP:    phase_d[PH_SAMP]  = 1'b1;
      CMP:     phase_d[PH_CMP]   = 1'b1;
      LOGIC:   phase_d[PH_LOGIC] = 1'b1;
      default: phase_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      sh_init <= '0; sh_samp <= '0; sh_cmp <= '0; sh_wait <= '0; sh_logic <= '0;
    end else if (latch_cfg) begin
      sh_init  <= cfg_t_init;
      sh_samp  <= cfg_t_samp;
      sh_cmp   <= cfg_t_cmp;
      sh_wait  <= cfg_t_wait;
      sh_logic <= cfg_t_logic;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      p_meta <= 1'b0; p_s <= 1'b0; n_meta <= 1'b0; n_s <= 1'b0;
    end else begin
      p_meta <= comp_out_p; p_s <= p_meta;
      n_meta <= comp_out_n; n_s <= n_meta;
    end
  end

  assign cap  = (state_q == WAIT) && tmr_last;
  assign push = (state_q == DONE);
  assign pop  = valid_q && res.res_ready;

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      k_q     <= '0;
      shift_q <= '0;
    end else begin
      if (state_q == SAMP) begin
        k_q <= KW'(N_BITS - 1);
      end else if ((state_q == LOGIC) && tmr_last && (k_q != '0)) begin
        k_q <= k_q - KW'(1);
      end
      if (cap) begin
        shift_q[k_q] <= p_s & ~n_s;
      end
    end
  end

  // A set event and clr_flags in the same cycle leave the flag set.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (push && (!valid_q || pop)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
      ovf_q <= (push && valid_q && !pop) | (ovf_q & ~clr_flags);
      bad_q <= (cap && (p_s == n_s)) | (bad_q & ~clr_flags);
      if (push) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign seq_init_p  = phase_q[PH_INIT];
  assign seq_init_n  = ~phase_q[PH_INIT];
  assign seq_samp_p  = phase_q[PH_SAMP];
  assign seq_samp_n  = ~phase_q[PH_SAMP];
  assign seq_cmp_p   = phase_q[PH_CMP];
  assign seq_cmp_n   = ~phase_q[PH_CMP];
  assign seq_logic_p = phase_q[PH_LOGIC];
  assign seq_logic_n = ~phase_q[PH_LOGIC];

  assign res.res_data  = data_q;
  assign res.res_valid = valid_q;
  assign busy          = (state_q != IDLE);
  assign overflow      = ovf_q;
  assign bad_diff      = bad_q;
  assign conv_count    = cnt_q;
  assign dbg_state     = state_q;

endmodule
